cache_dados: RTL and testbench

Direct-mapped, write-through data cache that answers the multicycle MIPS core's memory-stage requests. It receives `address`, `data`, active-low `r_en` and `w_en` from the core, and holds the core in its Memory state via `stall`. It returns read data on `saida_cache`. Misses and all writes are serviced through a simple ready-handshake port to main memory (`memoria_principal`).

---
 rtl/cache_dados_if.sv | 27 ++
 rtl/cache_dados.sv | 137 +++++++++++++
 tb/tb_cache_dados.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cache_dados_if.sv
// Core-side request/response and main-memory handshake bundle for cache_dados.
interface cache_dados_if;
  logic [11:0] address;
  logic [31:0] data;
  logic        r_en;
  logic        w_en;
  logic        stall;
  logic [31:0] saida_cache;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport master (
    output address, data, r_en, w_en, mem_rdata, mem_ready,
    input  stall, saida_cache, mem_addr, mem_wdata, mem_rd, mem_wr, hit_count, miss_count
  );

  modport slave (
    input  address, data, r_en, w_en, mem_rdata, mem_ready,
    output stall, saida_cache, mem_addr, mem_wdata, mem_rd, mem_wr, hit_count, miss_count
  );
endinterface

// File: rtl/cache_dados.sv
// Direct-mapped, write-through, write-allocate data cache for the multicycle MIPS memory stage.
// Read hits answer combinationally; misses and every write go through the ready handshake.
module cache_dados #(
  parameter int unsigned INDEX_W = 4
) (
  input logic          clk,
  input logic          rst,
  cache_dados_if.slave bus
);
  localparam int unsigned TagW  = 12 - INDEX_W;
  localparam int unsigned Lines = 1 << INDEX_W;

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StWdone} state_e;

  state_e              state_q, state_d;
  logic [Lines-1:0]    valid_q, valid_d;
  logic [TagW-1:0]     tag_q  [Lines];
  logic [31:0]         line_q [Lines];
  logic [11:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [15:0]         hit_count_q, hit_count_d;
  logic [15:0]         miss_count_q, miss_count_d;

  logic [INDEX_W-1:0]  idx, lidx;
  logic [TagW-1:0]     tag_in;
  logic                hit, is_wr, is_rd;
  logic                line_we;
  logic [31:0]         line_wdata;
  logic                stall;
  logic [31:0]         saida;

  assign idx    = bus.address[INDEX_W-1:0];
  assign tag_in = bus.address[11:INDEX_W];
  assign lidx   = addr_q[INDEX_W-1:0];
  assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);
  assign is_wr  = !bus.w_en;
  assign is_rd  = !bus.r_en && bus.w_en;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    line_we      = 1'b0;
    line_wdata   = bus.mem_rdata;
    stall        = 1'b0;
    saida        = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (is_wr) begin
          stall    = 1'b1;
          addr_d   = bus.address;
          wdata_d  = bus.data;
          mem_wr_d = 1'b1;
          state_d  = StWrite;
        end else if (is_rd) begin
          if (hit) begin
            saida = line_q[idx];
            if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
          end else begin
            stall    = 1'b1;
            addr_d   = bus.address;
            mem_rd_d = 1'b1;
            state_d  = StFill;
            if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
          end
        end
      end
      StFill: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          line_we       = 1'b1;
          valid_d[lidx] = 1'b1;
          mem_rd_d      = 1'b0;
          state_d       = StIdle;
        end
      end
      StWrite: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          line_we       = 1'b1;
          line_wdata    = wdata_q;
          valid_d[lidx] = 1'b1;
          mem_wr_d      = 1'b0;
          state_d       = StWdone;
        end
      end
      StWdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag/data arrays are qualified by valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_q[lidx] <= line_wdata;
      tag_q[lidx]  <= addr_q[11:INDEX_W];
    end
  end

  assign bus.stall       = stall;
  assign bus.saida_cache = saida;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.hit_count   = hit_count_q;
  assign bus.miss_count  = miss_count_q;
endmodule

// File: tb/tb_cache_dados.sv
// Directed bench for cache_dados: misses, hits, writes, index conflicts and mid-fill reset.
module tb_cache_dados;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cache_dados_if bus ();

  cache_dados #(.INDEX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic read_miss(input logic [11:0] a, input logic [31:0] rd, input int n);
    cyc();
    bus.address = a;
    bus.r_en    = 1'b0;
    #1 check("miss_req_stall", {31'b0, bus.stall}, 32'd1);
    for (int i = 1; i <= n; i++) begin
      cyc();
      if (i == n) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
      end
      #1;
      check("fill_stall", {31'b0, bus.stall}, 32'd1);
      check("fill_mem_rd", {31'b0, bus.mem_rd}, 32'd1);
      check("fill_mem_addr", {20'b0, bus.mem_addr}, {20'b0, a});
    end
    cyc();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    #1;
    check("refill_stall", {31'b0, bus.stall}, 32'd0);
    check("refill_data", bus.saida_cache, rd);
    check("refill_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    cyc();
    bus.r_en = 1'b1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input int n,
                          input logic also_rd);
    cyc();
    bus.address = a;
    bus.data    = d;
    bus.w_en    = 1'b0;
    bus.r_en    = also_rd ? 1'b0 : 1'b1;
    #1 check("wr_req_stall", {31'b0, bus.stall}, 32'd1);
    for (int i = 1; i <= n; i++) begin
      cyc();
      // Scramble the core bus; the latched request must still drive memory.
      bus.address = 12'hFFF;
      bus.data    = 32'h0;
      if (i == n) bus.mem_ready = 1'b1;
      #1;
      check("wr_stall", {31'b0, bus.stall}, 32'd1);
      check("wr_mem_wr", {31'b0, bus.mem_wr}, 32'd1);
      check("wr_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
      check("wr_mem_addr", {20'b0, bus.mem_addr}, {20'b0, a});
      check("wr_mem_wdata", bus.mem_wdata, d);
    end
    cyc();
    bus.mem_ready = 1'b0;
    bus.address   = a;
    bus.data      = d;
    #1;
    check("wdone_stall", {31'b0, bus.stall}, 32'd0);
    check("wdone_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    cyc();
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
  endtask

  task automatic read_hit(input logic [11:0] a, input logic [31:0] exp);
    cyc();
    bus.address = a;
    bus.r_en    = 1'b0;
    #1;
    check("hit_stall", {31'b0, bus.stall}, 32'd0);
    check("hit_data", bus.saida_cache, exp);
    cyc();
    bus.r_en = 1'b1;
    #1 check("hit_no_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
  endtask

  task automatic counts(input int h, input int m);
    #1;
    check("hit_count", {16'b0, bus.hit_count}, h);
    check("miss_count", {16'b0, bus.miss_count}, m);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.address   = 12'h0;
    bus.data      = 32'h0;
    bus.r_en      = 1'b1;
    bus.w_en      = 1'b1;
    bus.mem_rdata = 32'h0;
    bus.mem_ready = 1'b0;
    repeat (2) cyc();
    #1;
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    check("rst_saida", bus.saida_cache, 32'd0);
    check("rst_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    check("rst_mem_addr", {20'b0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    counts(0, 0);
    rst = 1'b1;

    read_miss(12'h010, 32'hDEADBEEF, 3);
    counts(1, 1);
    read_hit(12'h010, 32'hDEADBEEF);
    counts(2, 1);

    do_write(12'h020, 32'h12345678, 2, 1'b0);
    read_hit(12'h020, 32'h12345678);
    counts(3, 1);

    // 0x020 evicted 0x010 (index 0); re-cache it, then conflict with 0x030.
    read_miss(12'h010, 32'hA5A5A5A5, 1);
    read_miss(12'h030, 32'h30303030, 2);
    read_miss(12'h010, 32'h0BADF00D, 1);
    counts(6, 4);

    do_write(12'h045, 32'hCAFEF00D, 1, 1'b1);
    read_hit(12'h045, 32'hCAFEF00D);
    counts(7, 4);

    // Reset in the middle of a fill.
    cyc();
    bus.address = 12'h077;
    bus.r_en    = 1'b0;
    cyc();
    #1 check("pre_rst_mem_rd", {31'b0, bus.mem_rd}, 32'd1);
    #2 rst = 1'b0;
    #1 check("async_rst_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    bus.r_en = 1'b1;
    cyc();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h77777777;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("late_ready_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("late_ready_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    counts(0, 0);
    read_miss(12'h045, 32'h45454545, 2);
    counts(1, 1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
